direct_mapped_cache: RTL and testbench
======================================

Name: direct_mapped_cache

Overview:
Read-only, direct-mapped, write-allocate-free byte cache placed between the grader's request port and the burst memory wrapper. It accepts single-byte read requests on a 10-bit address space and serves hits from internal line storage. On a miss it refills a whole line from memory with one burst, then returns the requested byte. It is the cache unit the grader drives through its rreq/rvalid port.

Parameters:
NUM_LINES, 16, number of cache lines; power of two, 2..64.
LINE_BYTES, 4, bytes per line; fixed at 4 so that burst_len_to_mem = 2'b11.
ADDR_W, 10, byte address width.
DATA_W, 8, data width.

Ports:
clk  in  1  clock.
reset  in  1  reset.
raddr_from_top  in  10  byte read address; stable while rreq_from_top=1.
rreq_from_top  in  1  read request; held high until rvalid_to_top is seen.
rdata_to_top  out  8  read data; valid when rvalid_to_top=1.
rvalid_to_top  out  1  one-cycle response pulse.
rreq_to_mem  out  1  burst read request to memory.
raddr_to_mem  out  10  line-aligned burst start address.
burst_len_to_mem  out  2  beats minus one.
rdata_from_mem  in  8  burst beat data.
rvalid_from_mem  in  1  beat valid.
rlast_from_mem  in  1  final beat marker; qualified by rvalid_from_mem.

Behaviour:
- Reset is synchronous and active-high on clock clk. During reset all valid bits clear, FSM=IDLE, every output is 0, and the beat counter is 0. Tag and data arrays are not cleared.
- Address split at the defaults: offset=[1:0], index=[5:2] (log2 NUM_LINES bits), tag=the remaining upper bits, [9:6].
- All outputs are registered. rdata_to_top holds its last value when rvalid_to_top=0.
- FSM IDLE: if rreq_from_top=1, latch the address and go to LOOKUP.
- FSM LOOKUP: compare valid[index] and tag[index] against the latched tag.
  - Hit: go to RESP with data[index][offset].
  - Miss: go to MISS_REQ.
- FSM MISS_REQ:
  - Drive rreq_to_mem=1, raddr_to_mem={tag,index,2'b00}, burst_len_to_mem=2'b11.
  - Hold these values until the first rvalid_from_mem=1.
  - That beat is written as byte 0, and rreq_to_mem drops in the next cycle. Go to REFILL, or directly to RESP if that beat also has rlast.
- FSM REFILL:
  - On each rvalid_from_mem=1, write rdata_from_mem to byte [beat_cnt] and increment beat_cnt.
  - Writes are suppressed once beat_cnt reaches LINE_BYTES; extra beats are ignored.
  - Cycles with rvalid_from_mem=0 are stalls and change nothing.
  - On rvalid_from_mem & rlast_from_mem: set valid[index]=1, write tag[index], clear beat_cnt, go to RESP.
  - If the requested byte arrives in that same last beat, it is forwarded from rdata_from_mem.
- FSM RESP: rvalid_to_top=1 for exactly one cycle with the requested byte, then go to IDLE.
- Latency:
  - Hit: rvalid_to_top rises 2 cycles after the cycle rreq_from_top is first sampled high in IDLE.
  - Miss: rvalid_to_top rises 1 cycle after the rlast beat.
- Back-to-back requests: rreq_from_top=1 in IDLE after RESP starts a new request. The top deasserts rreq within 1 cycle of rvalid. rreq_from_top is ignored in every state except IDLE.
- Request dropped mid-refill: the refill still completes and the line is installed. The RESP pulse is still issued.
- Reset during a refill: the line stays invalid, and the next access to that line misses. The memory wrapper shares the reset, so no stale beats arrive.
- A refill overwrites the victim line unconditionally. No dirty state exists.

Decomposition:
- Shared package cache_pkg:
  - State enum {IDLE, LOOKUP, MISS_REQ, REFILL, RESP}.
  - Width constants: OFFSET_W=2, INDEX_W=$clog2(NUM_LINES), TAG_W=ADDR_W-OFFSET_W-INDEX_W.
  - BURST_LEN_LINE=2'b11.
- One sub-module, cache_line_store: valid, tag and data arrays, a single write port (index, byte, data, set_valid) and a combinational read of the tag and byte. The FSM, address latch and memory handshake stay in the top block.

Test Plan:
1. Cold miss.
   - Stimulus: after reset, read 0x000; memory returns 0xA0,0xA1,0xA2,0xA3.
   - Required: one rreq_to_mem with raddr_to_mem=0x000 and burst_len=2'b11; rvalid_to_top pulses once with 0xA0, 1 cycle after rlast.
2. Hit.
   - Stimulus: read 0x002 next.
   - Required: no rreq_to_mem; rvalid_to_top exactly 2 cycles after rreq, data 0xA2.
3. Conflict.
   - Stimulus: read 0x040 (index 0, tag 1), then read 0x001.
   - Required: both miss; second refill raddr_to_mem=0x000; returns the 0xA1 memory value.
4. Memory stalls.
   - Stimulus: 3 idle cycles between each beat; request 0x007.
   - Required: data equals beat 3; one rvalid pulse; rreq_to_mem drops the cycle after beat 0.
5. Reset mid-refill.
   - Stimulus: assert reset after beat 1 of the 0x000 refill.
   - Required: all outputs 0 during reset; the following read of 0x000 issues a new burst.
6. Full sweep.
   - Stimulus: sequential reads 0x000..0x3FF against a golden ROM.
   - Required: all bytes match; exactly 256 bursts issued; reads at offsets 1..3 are hits.

Source files
------------

// File: rtl/direct_mapped_cache_pkg.sv
// Shared types and width constants for the read-only direct-mapped byte cache.
package cache_pkg;

    localparam int CACHE_LINES = 16;
    localparam int CACHE_ADDR_W = 10;
    localparam int OFFSET_W = 2;
    localparam int INDEX_W = $clog2(CACHE_LINES);
    localparam int TAG_W = CACHE_ADDR_W - OFFSET_W - INDEX_W;

    localparam logic [1:0] BURST_LEN_LINE = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        REFILL,
        RESP
    } state_t;

endpackage

// File: rtl/direct_mapped_cache_line_store.sv
// Valid/tag/data arrays of the cache: one write port, combinational tag and byte read.
// Only the valid bits are reset; tag and data contents are don't-care until valid.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_BITS = 4,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_W-1:0]    rd_index,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic                rd_valid,
    output logic [TAG_BITS-1:0] rd_tag,
    output logic [DATA_W-1:0]   rd_byte,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_index,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_set_valid,
    input  logic [TAG_BITS-1:0] wr_tag
);

    localparam int LINE_BYTES = 2 ** OFFSET_W;

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
    logic [TAG_BITS-1:0]  tag_d  [NUM_LINES];
    logic [DATA_W-1:0]    data_q [NUM_LINES][LINE_BYTES];
    logic [DATA_W-1:0]    data_d [NUM_LINES][LINE_BYTES];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            data_d[wr_index][wr_offset] = wr_data;
        end
        // The tag is committed together with the valid bit, at the end of a refill.
        if (wr_set_valid) begin
            valid_d[wr_index] = 1'b1;
            tag_d[wr_index]   = wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_byte  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/direct_mapped_cache.sv
// Read-only direct-mapped byte cache: hits answer 2 cycles after the request, misses
// refill a whole line by one memory burst and answer 1 cycle after the last beat.
module direct_mapped_cache
    import cache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int LINE_BYTES = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] raddr_from_top,
    input  logic              rreq_from_top,
    output logic [DATA_W-1:0] rdata_to_top,
    output logic              rvalid_to_top,
    output logic              rreq_to_mem,
    output logic [ADDR_W-1:0] raddr_to_mem,
    output logic [1:0]        burst_len_to_mem,
    input  logic [DATA_W-1:0] rdata_from_mem,
    input  logic              rvalid_from_mem,
    input  logic              rlast_from_mem
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_BITS = ADDR_W - OFFSET_W - IDX_W;
    localparam int BEAT_W = $clog2(LINE_BYTES) + 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [1:0]          burst_len_q, burst_len_d;

    logic [OFFSET_W-1:0] req_offset;
    logic [IDX_W-1:0]    req_index;
    logic [TAG_BITS-1:0] req_tag;
    logic                rd_valid;
    logic [TAG_BITS-1:0] rd_tag;
    logic [DATA_W-1:0]   rd_byte;
    logic                beat_in;
    logic                wr_en;
    logic                wr_set_valid;
    logic [DATA_W-1:0]   resp_byte;

    assign req_offset = addr_q[OFFSET_W-1:0];
    assign req_index  = addr_q[OFFSET_W +: IDX_W];
    assign req_tag    = addr_q[ADDR_W-1 -: TAG_BITS];

    assign beat_in      = ((state_q == MISS_REQ) || (state_q == REFILL)) && rvalid_from_mem;
    assign wr_en        = beat_in && (beat_cnt_q < BEAT_W'(LINE_BYTES));
    assign wr_set_valid = beat_in && rlast_from_mem;
    // The requested byte may be arriving on this very beat and is not in the store yet.
    assign resp_byte    = (wr_en && (beat_cnt_q[OFFSET_W-1:0] == req_offset)) ?
                          rdata_from_mem : rd_byte;

    cache_line_store #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_BITS  (TAG_BITS),
        .DATA_W    (DATA_W)
    ) u_store (
        .clk          (clk),
        .reset        (reset),
        .rd_index     (req_index),
        .rd_offset    (req_offset),
        .rd_valid     (rd_valid),
        .rd_tag       (rd_tag),
        .rd_byte      (rd_byte),
        .wr_en        (wr_en),
        .wr_index     (req_index),
        .wr_offset    (beat_cnt_q[OFFSET_W-1:0]),
        .wr_data      (rdata_from_mem),
        .wr_set_valid (wr_set_valid),
        .wr_tag       (req_tag)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        beat_cnt_d  = beat_cnt_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        burst_len_d = burst_len_q;
        case (state_q)
            IDLE: begin
                if (rreq_from_top) begin
                    addr_d  = raddr_from_top;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (rd_valid && (rd_tag == req_tag)) begin
                    rdata_d  = rd_byte;
                    rvalid_d = 1'b1;
                    state_d  = RESP;
                end else begin
                    mem_req_d   = 1'b1;
                    mem_addr_d  = {req_tag, req_index, {OFFSET_W{1'b0}}};
                    burst_len_d = BURST_LEN_LINE;
                    state_d     = MISS_REQ;
                end
            end
            MISS_REQ, REFILL: begin
                if (beat_in) begin
                    mem_req_d = 1'b0;
                    state_d   = REFILL;
                    if (wr_en) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                    if (rlast_from_mem) begin
                        beat_cnt_d = '0;
                        rdata_d    = resp_byte;
                        rvalid_d   = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            RESP: begin
                rvalid_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            beat_cnt_q  <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            burst_len_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            beat_cnt_q  <= beat_cnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            burst_len_q <= burst_len_d;
        end
    end

    assign rdata_to_top     = rdata_q;
    assign rvalid_to_top    = rvalid_q;
    assign rreq_to_mem      = mem_req_q;
    assign raddr_to_mem     = mem_addr_q;
    assign burst_len_to_mem = burst_len_q;

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Bench for direct_mapped_cache: burst-memory responder backed by a ROM, a line-level
// hit/miss model, directed vectors, stall/reset corner cases, random reads and a full sweep.
module tb_direct_mapped_cache;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] raddr_from_top;
    logic       rreq_from_top;
    logic [7:0] rdata_to_top;
    logic       rvalid_to_top;
    logic       rreq_to_mem;
    logic [9:0] raddr_to_mem;
    logic [1:0] burst_len_to_mem;
    logic [7:0] rdata_from_mem;
    logic       rvalid_from_mem;
    logic       rlast_from_mem;

    always #5 clk = ~clk;

    direct_mapped_cache dut (
        .clk              (clk),
        .reset            (reset),
        .raddr_from_top   (raddr_from_top),
        .rreq_from_top    (rreq_from_top),
        .rdata_to_top     (rdata_to_top),
        .rvalid_to_top    (rvalid_to_top),
        .rreq_to_mem      (rreq_to_mem),
        .raddr_to_mem     (raddr_to_mem),
        .burst_len_to_mem (burst_len_to_mem),
        .rdata_from_mem   (rdata_from_mem),
        .rvalid_from_mem  (rvalid_from_mem),
        .rlast_from_mem   (rlast_from_mem)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic [7:0] rom [1024];

    // Reference model: which tag each line slot holds, by address arithmetic.
    bit mdl_valid [16];
    int mdl_tag   [16];

    function automatic bit model_access(input logic [9:0] a);
        int idx = (int'(a) / 4) % 16;
        int t   = int'(a) / 64;
        bit h   = mdl_valid[idx] && (mdl_tag[idx] == t);
        mdl_valid[idx] = 1'b1;
        mdl_tag[idx]   = t;
        return h;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mdl_valid[i] = 1'b0;
    endtask

    int cyc = 0;
    int pulses = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rvalid_to_top) pulses <= pulses + 1;

    // Memory responder
    int mem_gap = 0;
    int mem_lat_max = 2;
    int bursts = 0;
    int beats_sent = 0;
    int last_beat_cyc = -10;
    logic [9:0] exp_burst_addr = '0;

    initial begin : mem_resp
        logic [9:0] base;
        bit aborted;
        rvalid_from_mem = 1'b0;
        rlast_from_mem  = 1'b0;
        rdata_from_mem  = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (!reset && rreq_to_mem) begin
                base = raddr_to_mem;
                bursts++;
                beats_sent = 0;
                aborted = 1'b0;
                chk("burst_addr", 32'(raddr_to_mem), 32'(exp_burst_addr));
                chk("burst_len", 32'(burst_len_to_mem), 32'd3);
                repeat ($urandom_range(0, mem_lat_max)) begin
                    @(posedge clk); #1;
                    if (reset) aborted = 1'b1;
                end
                for (int b = 0; b < 4 && !aborted; b++) begin
                    rvalid_from_mem = 1'b1;
                    rdata_from_mem  = rom[int'(base) + b];
                    rlast_from_mem  = (b == 3);
                    beats_sent      = b + 1;
                    if (b == 3) last_beat_cyc = cyc;
                    @(posedge clk); #1;
                    rvalid_from_mem = 1'b0;
                    rlast_from_mem  = 1'b0;
                    if (reset) aborted = 1'b1;
                    else if (b == 0) chk("rreq_drop_after_beat0", 32'(rreq_to_mem), 32'd0);
                    for (int g = 0; g < mem_gap && !aborted && b < 3; g++) begin
                        @(posedge clk); #1;
                        if (reset) aborted = 1'b1;
                    end
                end
            end
        end
    end

    task automatic check_outputs_zero(input string nm);
        chk({nm, "_rvalid"}, 32'(rvalid_to_top), 32'd0);
        chk({nm, "_rdata"}, 32'(rdata_to_top), 32'd0);
        chk({nm, "_memreq"}, {19'd0, rreq_to_mem, raddr_to_mem, burst_len_to_mem}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        rreq_from_top = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        model_clear();
    endtask

    task automatic do_read(input logic [9:0] a, output logic [7:0] d, output bit got,
                           output int lat, output int bdelta, output int rcyc);
        int b0 = bursts;
        exp_burst_addr = {a[9:2], 2'b00};
        raddr_from_top = a;
        rreq_from_top  = 1'b1;
        got = 1'b0;
        lat = 0;
        rcyc = 0;
        d = 8'hxx;
        for (int n = 1; n <= 60 && !got; n++) begin
            @(posedge clk); #1;
            if (rvalid_to_top) begin
                got = 1'b1;
                lat = n;
                d = rdata_to_top;
                rcyc = cyc;
                rreq_from_top = 1'b0;
            end
        end
        rreq_from_top = 1'b0;
        chk("read_response_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        chk("rvalid_one_cycle", 32'(rvalid_to_top), 32'd0);
        bdelta = bursts - b0;
    endtask

    task automatic run_read(input logic [9:0] a, input logic [7:0] exp_d, input bit exp_hit,
                            input string nm);
        logic [7:0] d;
        bit got;
        int lat, bd, rc;
        do_read(a, d, got, lat, bd, rc);
        chk({nm, "_data"}, 32'(d), 32'(exp_d));
        chk({nm, "_bursts"}, 32'(bd), exp_hit ? 32'd0 : 32'd1);
        if (exp_hit) chk({nm, "_hit_latency"}, 32'(lat), 32'd2);
        else chk({nm, "_miss_latency"}, 32'(rc), 32'(last_beat_cyc + 1));
    endtask

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
        bit         hit;
        string      name;
    } vec_t;

    vec_t vecs [4];

    initial begin : watchdog
        #700000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int p0, b0, n;
        logic [9:0] a;

        reset = 1'b1;
        rreq_from_top = 1'b0;
        raddr_from_top = '0;
        for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
        rom[0] = 8'hA0; rom[1] = 8'hA1; rom[2] = 8'hA2; rom[3] = 8'hA3;
        rom[4] = 8'hC0; rom[5] = 8'hC1; rom[6] = 8'hC2; rom[7] = 8'hC3;
        rom[64] = 8'hB0; rom[65] = 8'hB1; rom[66] = 8'hB2; rom[67] = 8'hB3;

        vecs[0] = '{10'h000, 8'hA0, 1'b0, "cold_miss"};
        vecs[1] = '{10'h002, 8'hA2, 1'b1, "hit"};
        vecs[2] = '{10'h040, 8'hB0, 1'b0, "conflict_a"};
        vecs[3] = '{10'h001, 8'hA1, 1'b0, "conflict_b"};

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("initial_reset");
        reset = 1'b0;
        model_clear();

        foreach (vecs[i]) begin
            void'(model_access(vecs[i].addr));
            run_read(vecs[i].addr, vecs[i].data, vecs[i].hit, vecs[i].name);
        end

        // Memory stalls between beats; requested byte comes on the final beat.
        mem_gap = 3;
        p0 = pulses;
        void'(model_access(10'h007));
        run_read(10'h007, 8'hC3, 1'b0, "stall");
        chk("stall_pulses", 32'(pulses - p0), 32'd1);
        mem_gap = 0;

        // Reset in the middle of a refill of line 0.
        do_reset();
        mem_lat_max = 0;
        beats_sent = 0;
        exp_burst_addr = 10'h000;
        raddr_from_top = 10'h000;
        rreq_from_top = 1'b1;
        n = 0;
        while (beats_sent < 2 && n < 40) begin
            @(posedge clk); #2;
            n++;
        end
        chk("midrefill_reached_beat1", 32'(beats_sent >= 2), 32'd1);
        @(posedge clk); #2;
        reset = 1'b1;
        rreq_from_top = 1'b0;
        @(posedge clk); #1;
        check_outputs_zero("midrefill_reset");
        @(posedge clk); #1;
        check_outputs_zero("midrefill_reset_hold");
        reset = 1'b0;
        model_clear();
        mem_lat_max = 2;
        void'(model_access(10'h000));
        run_read(10'h000, 8'hA0, 1'b0, "after_reset");

        // Random reads over a few tags so that hits and conflicts both occur.
        for (int i = 0; i < 300; i++) begin
            bit h;
            a = 10'(($urandom_range(0, 3) << 6) | $urandom_range(0, 63));
            mem_gap = $urandom_range(0, 2);
            h = model_access(a);
            run_read(a, rom[a], h, "random");
        end
        mem_gap = 0;

        // Full sequential sweep from a cold cache.
        do_reset();
        b0 = bursts;
        for (int i = 0; i < 1024; i++) begin
            bit h;
            a = 10'(i);
            h = model_access(a);
            run_read(a, rom[a], h, "sweep");
        end
        chk("sweep_bursts", 32'(bursts - b0), 32'd256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
